// File: rtl/lsu_rmw_if.sv
// Request/response and dmem bus bundle for the read-modify-write load/store unit.
// master = processor + dmem side, slave = the LSU itself.
interface lsu_rmw_if #(
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = DATA_W / 8;

    logic                ip_req_valid;
    logic                op_req_ready;
    logic                ip_req_wr;
    logic [1:0]          ip_req_size;
    logic                ip_req_unsigned;
    logic [ADDR_W-1:0]   ip_req_addr;
    logic [DATA_W-1:0]   ip_req_wdata;

    logic                op_resp_valid;
    logic [DATA_W-1:0]   op_resp_rdata;
    logic                op_resp_err;

    logic [ADDR_W-1:0]   op_data_addr;
    logic                op_data_rd;
    logic                ip_data_valid;
    logic [DATA_W-1:0]   ip_data_from_dmem;
    logic                op_data_wr;
    logic [MASK_W-1:0]   op_data_mask;
    logic [DATA_W-1:0]   op_data_to_dmem;

    modport master (
        output ip_req_valid, ip_req_wr, ip_req_size, ip_req_unsigned, ip_req_addr, ip_req_wdata,
        output ip_data_valid, ip_data_from_dmem,
        input  op_req_ready, op_resp_valid, op_resp_rdata, op_resp_err,
        input  op_data_addr, op_data_rd, op_data_wr, op_data_mask, op_data_to_dmem
    );

    modport slave (
        input  ip_req_valid, ip_req_wr, ip_req_size, ip_req_unsigned, ip_req_addr, ip_req_wdata,
        input  ip_data_valid, ip_data_from_dmem,
        output op_req_ready, op_resp_valid, op_resp_rdata, op_resp_err,
        output op_data_addr, op_data_rd, op_data_wr, op_data_mask, op_data_to_dmem
    );
endinterface

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only dmem: extends loads, turns sub-word
// stores into read-modify-write, and rejects misaligned or illegal-size requests.
module lsu_rmw #(
    parameter int unsigned ADDR_W = 32
) (
    input logic      clk,
    input logic      rst,
    lsu_rmw_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned HALF_W = 16;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e state_q, state_d;

    // captured request
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [HALF_W-1:0] wdata_q, wdata_d;

    // output registers
    logic              ready_q, ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;
    logic              data_rd_q, data_rd_d;
    logic              data_wr_q, data_wr_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] to_dmem_q, to_dmem_d;

    logic accept_c;
    logic misalign_c;
    logic word_store_c;

    function automatic logic [DATA_W-1:0] extend_load(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        size,
        input logic [LANE_W-1:0] lane,
        input logic              uns
    );
        logic [7:0]        b;
        logic [HALF_W-1:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    extend_load = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_H:    extend_load = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: extend_load = word;
        endcase
    endfunction

    function automatic logic [MASK_W-1:0] lane_mask(
        input logic [1:0]        size,
        input logic [LANE_W-1:0] lane
    );
        case (size)
            SZ_B:    lane_mask = MASK_W'(1) << lane;
            SZ_H:    lane_mask = MASK_W'(3) << lane;
            default: lane_mask = '1;
        endcase
    endfunction

    // Overlay the store bytes on the word read back from dmem.
    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] word,
        input logic [HALF_W-1:0] wdata,
        input logic [1:0]        size,
        input logic [MASK_W-1:0] mask
    );
        merge_word = word;
        for (int i = 0; i < int'(MASK_W); i++) begin
            if (mask[i]) begin
                merge_word[i*8 +: 8] = (size == SZ_H) ? wdata[(i % 2)*8 +: 8] : wdata[7:0];
            end
        end
    endfunction

    assign accept_c     = (state_q == IDLE) && bus.ip_req_valid;
    assign word_store_c = bus.ip_req_wr && (bus.ip_req_size == SZ_W);

    always_comb begin
        misalign_c = 1'b0;
        case (bus.ip_req_size)
            SZ_B:    misalign_c = 1'b0;
            SZ_H:    misalign_c = bus.ip_req_addr[0];
            SZ_W:    misalign_c = |bus.ip_req_addr[1:0];
            default: misalign_c = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.ip_req_valid) begin
                    if (misalign_c)        state_d = RESP;
                    else if (word_store_c) state_d = WR;
                    else                   state_d = RD;
                end
            end
            RD: begin
                if (bus.ip_data_valid) state_d = wr_q ? WR : RESP;
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and capture logic; outputs are registered from the next state.
    always_comb begin
        wr_d         = wr_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        ready_d      = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        data_rd_d    = (state_d == RD);
        data_wr_d    = (state_d == WR);
        rdata_d      = '0;
        err_d        = 1'b0;
        mask_d       = '0;
        to_dmem_d    = '0;
        data_addr_d  = data_addr_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    wr_d       = bus.ip_req_wr;
                    size_d     = bus.ip_req_size;
                    unsigned_d = bus.ip_req_unsigned;
                    lane_d     = bus.ip_req_addr[LANE_W-1:0];
                    wdata_d    = bus.ip_req_wdata[HALF_W-1:0];
                    err_d      = misalign_c;
                    if (!misalign_c) begin
                        data_addr_d = ADDR_W'(bus.ip_req_addr >> 2);
                    end
                    if (!misalign_c && word_store_c) begin
                        to_dmem_d = bus.ip_req_wdata;
                        mask_d    = '1;
                    end
                end
            end
            RD: begin
                if (bus.ip_data_valid) begin
                    if (wr_q) begin
                        mask_d    = lane_mask(size_q, lane_q);
                        to_dmem_d = merge_word(bus.ip_data_from_dmem, wdata_q, size_q,
                                               lane_mask(size_q, lane_q));
                    end else begin
                        rdata_d = extend_load(bus.ip_data_from_dmem, size_q, lane_q, unsigned_q);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q         <= 1'b0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            lane_q       <= '0;
            wdata_q      <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            data_addr_q  <= '0;
            data_rd_q    <= 1'b0;
            data_wr_q    <= 1'b0;
            mask_q       <= '0;
            to_dmem_q    <= '0;
        end else begin
            wr_q         <= wr_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            data_addr_q  <= data_addr_d;
            data_rd_q    <= data_rd_d;
            data_wr_q    <= data_wr_d;
            mask_q       <= mask_d;
            to_dmem_q    <= to_dmem_d;
        end
    end

    assign bus.op_req_ready    = ready_q;
    assign bus.op_resp_valid   = resp_valid_q;
    assign bus.op_resp_rdata   = rdata_q;
    assign bus.op_resp_err     = err_q;
    assign bus.op_data_addr    = data_addr_q;
    assign bus.op_data_rd      = data_rd_q;
    assign bus.op_data_wr      = data_wr_q;
    assign bus.op_data_mask    = mask_q;
    assign bus.op_data_to_dmem = to_dmem_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw: directed requests push expected responses and
// dmem writes; a negedge monitor pops and compares them as the DUT presents them.
module tb_lsu_rmw;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_rmw_if #(.ADDR_W(32)) bus ();
    lsu_rmw #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [31:0] rdata; logic err; int lat; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] mask; } wr_t;
    resp_t exp_q[$];
    wr_t   wexp_q[$];

    int checks = 0, errors = 0;
    int cyc = 0, acc_cyc = 0, acc_cnt = 0;
    int rd_total = 0, wr_total = 0;
    int stall_n = 0, rd_run = 0;
    bit mon_en = 1'b0;

    logic [31:0] mem [0:15];
    bit          poke_en = 1'b0;
    logic [3:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // dmem model: combinational read, optional stall, masked write on the edge
    assign bus.ip_data_valid     = bus.op_data_rd && (rd_run >= stall_n);
    assign bus.ip_data_from_dmem = mem[bus.op_data_addr[3:0]];

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (bus.op_data_wr) begin
            for (int i = 0; i < 4; i++)
                if (bus.op_data_mask[i]) mem[bus.op_data_addr[3:0]][i*8 +: 8] <= bus.op_data_to_dmem[i*8 +: 8];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) rd_run <= 0;
        else     rd_run <= bus.op_data_rd ? rd_run + 1 : 0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // accept tracking and no-accept-in-RESP check
    always @(posedge clk) begin
        if (!rst && bus.ip_req_valid && bus.op_req_ready) begin
            acc_cnt++;
            acc_cyc = cyc;
        end
        if (!rst && bus.ip_req_valid && bus.op_resp_valid)
            chk("ready_in_resp", 32'(bus.op_req_ready), 32'd0);
    end

    // monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.op_data_rd) rd_total++;
            if (bus.op_data_wr) wr_total++;
            if (mon_en) begin
                if (!bus.op_data_rd && !bus.op_data_wr) begin
                    chk("idle_mask", 32'(bus.op_data_mask), 32'd0);
                    chk("idle_data", bus.op_data_to_dmem, 32'd0);
                end
                if (bus.op_resp_valid) begin
                    if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                    else begin
                        resp_t e;
                        e = exp_q.pop_front();
                        chk("resp_rdata", bus.op_resp_rdata, e.rdata);
                        chk("resp_err", 32'(bus.op_resp_err), 32'(e.err));
                        chk("resp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    end
                end
                if (bus.op_data_wr) begin
                    if (wexp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                    else begin
                        wr_t w;
                        w = wexp_q.pop_front();
                        chk("wr_addr", bus.op_data_addr, w.addr);
                        chk("wr_data", bus.op_data_to_dmem, w.data);
                        chk("wr_mask", 32'(bus.op_data_mask), 32'(w.mask));
                    end
                end
            end
        end
    end

    task automatic poke(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(posedge clk); #1 poke_en = 1'b0;
    endtask

    task automatic drive(input bit wr, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.ip_req_wr = wr; bus.ip_req_size = size; bus.ip_req_unsigned = uns;
        bus.ip_req_addr = addr; bus.ip_req_wdata = wdata;
    endtask

    task automatic issue(input bit wr, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input bit exp_err, input int exp_lat,
                         input int exp_rd, input int exp_wr, input logic [31:0] exp_waddr,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_mask);
        int rd0, wr0;
        bit done;
        exp_q.push_back('{exp_rdata, exp_err, exp_lat});
        if (exp_wr != 0) wexp_q.push_back('{exp_waddr, exp_wdata, exp_mask});
        @(negedge clk);
        rd0 = rd_total; wr0 = wr_total;
        drive(wr, size, uns, addr, wdata);
        bus.ip_req_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.op_req_ready) begin
                @(posedge clk); #1 bus.ip_req_valid = 1'b0; done = 1'b1;
            end else @(negedge clk);
        end
        if (!done) begin
            bus.ip_req_valid = 1'b0;
            chk("accept_timeout", 32'd1, 32'd0);
        end
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk); #2;
            if (exp_q.size() == 0 && wexp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            chk("resp_timeout", 32'(exp_q.size() + wexp_q.size()), 32'd0);
            exp_q.delete(); wexp_q.delete();
        end
        chk("rd_cycles", 32'(rd_total - rd0), 32'(exp_rd));
        chk("wr_cycles", 32'(wr_total - wr0), 32'(exp_wr));
    endtask

    task automatic ld(input logic [1:0] size, input bit uns, input logic [31:0] addr,
                      input logic [31:0] exp);
        issue(1'b0, size, uns, addr, 32'h0, exp, 1'b0, 2 + stall_n, 1 + stall_n, 0, '0, '0, '0);
    endtask

    task automatic st(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_word, input logic [3:0] exp_mask);
        bit word;
        word = (size == 2'd2);
        issue(1'b1, size, 1'b0, addr, wdata, 32'h0, 1'b0, word ? 2 : 3, word ? 0 : 1, 1,
              addr >> 2, exp_word, exp_mask);
    endtask

    task automatic bad(input bit wr, input logic [1:0] size, input logic [31:0] addr);
        issue(wr, size, 1'b0, addr, 32'hDEADBEEF, 32'h0, 1'b1, 1, 0, 0, '0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ip_req_valid = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) poke(4'(i), 32'h0);
        poke(4'd4, 32'h8899AABB);
        poke(4'd5, 32'h11223344);

        // reset values
        @(negedge clk);
        chk("rst_ready", 32'(bus.op_req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.op_resp_valid), 32'd0);
        chk("rst_data_rd", 32'(bus.op_data_rd), 32'd0);
        chk("rst_data_wr", 32'(bus.op_data_wr), 32'd0);
        chk("rst_data_addr", bus.op_data_addr, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // loads and extension
        ld(2'd2, 1'b0, 32'h10, 32'h8899AABB);
        ld(2'd0, 1'b0, 32'h13, 32'hFFFFFF88);
        ld(2'd0, 1'b1, 32'h13, 32'h00000088);
        ld(2'd1, 1'b0, 32'h12, 32'hFFFF8899);
        ld(2'd1, 1'b1, 32'h10, 32'h0000AABB);
        ld(2'd0, 1'b0, 32'h10, 32'hFFFFFFBB);
        ld(2'd0, 1'b1, 32'h11, 32'h000000AA);
        ld(2'd2, 1'b1, 32'h10, 32'h8899AABB);

        // sub-word and word stores
        st(2'd0, 32'h15, 32'h0000005A, 32'h11225A44, 4'b0010);
        ld(2'd2, 1'b0, 32'h14, 32'h11225A44);
        st(2'd1, 32'h16, 32'hFFFFBEEF, 32'hBEEF5A44, 4'b1100);
        ld(2'd2, 1'b0, 32'h14, 32'hBEEF5A44);
        st(2'd2, 32'h18, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111);
        ld(2'd1, 1'b1, 32'h1A, 32'h0000CAFE);
        ld(2'd1, 1'b0, 32'h18, 32'hFFFFF00D);
        st(2'd0, 32'h18, 32'h12345677, 32'hCAFEF077, 4'b0001);
        ld(2'd2, 1'b0, 32'h18, 32'hCAFEF077);

        // misaligned and illegal size
        bad(1'b1, 2'd1, 32'h13);
        bad(1'b0, 2'd2, 32'h12);
        bad(1'b0, 2'd3, 32'h10);
        bad(1'b1, 2'd2, 32'h11);
        ld(2'd2, 1'b0, 32'h10, 32'h8899AABB);

        // dmem stall during a half load
        stall_n = 3;
        ld(2'd1, 1'b0, 32'h12, 32'hFFFF8899);
        stall_n = 0;

        // reset while the write is on the bus
        mon_en = 1'b0;
        @(negedge clk);
        drive(1'b1, 2'd0, 1'b0, 32'h10, 32'h00000000);
        bus.ip_req_valid = 1'b1;
        @(posedge clk); #1 bus.ip_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wr_before_rst", 32'(bus.op_data_wr), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_wr", 32'(bus.op_data_wr), 32'd0);
        chk("async_rst_ready", 32'(bus.op_req_ready), 32'd1);
        chk("async_rst_mask", 32'(bus.op_data_mask), 32'd0);
        chk("async_rst_resp", 32'(bus.op_resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_no_resp", 32'(bus.op_resp_valid), 32'd0);
        mon_en = 1'b1;
        ld(2'd2, 1'b0, 32'h10, 32'h8899AABB);

        // back-to-back with valid held high
        begin
            int base;
            bit done;
            base = acc_cnt;
            for (int i = 0; i < 3; i++) exp_q.push_back('{32'hBEEF5A44, 1'b0, 2});
            @(negedge clk);
            drive(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
            bus.ip_req_valid = 1'b1;
            done = 1'b0;
            for (int i = 0; i < 30 && !done; i++) begin
                @(negedge clk); #2;
                if (exp_q.size() == 0) done = 1'b1;
            end
            bus.ip_req_valid = 1'b0;
            if (!done) begin
                chk("b2b_timeout", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
            end
            repeat (3) @(negedge clk);
            chk("b2b_accepts", 32'(acc_cnt - base), 32'd3);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
